// File: rtl/fifo_write_sched_if.sv
// Bundle between the write scheduler, its four requesters and the packet writer.
// Handshakes: req[i] is held high until ack[i] pulses; fs stays high until fd is seen, and fd drops after fs does.
interface fifo_write_sched_if;
    logic [3:0]  req;
    logic [47:0] len_bus;
    logic [3:0]  ack;
    logic [3:0]  gnt;
    logic        fs;
    logic        fd;
    logic [11:0] data_len;
    logic [15:0] part;
    logic        err;
    logic [7:0]  so;

    modport master (
        input  req, len_bus, fd,
        output ack, gnt, fs, data_len, part, err, so
    );

    modport slave (
        output req, len_bus, fd,
        input  ack, gnt, fs, data_len, part, err, so
    );
endinterface

// File: rtl/fifo_write_sched.sv
// Round-robin scheduler sharing one packet writer among four sources,
// with header/sequence generation and a watchdog on the writer's done.
module fifo_write_sched #(
    parameter int unsigned TO_CYC = 4096
) (
    input logic                clk,
    input logic                rst,
    fifo_write_sched_if.master bus
);
    typedef enum logic [7:0] {
        S_IDLE  = 8'h01,
        S_ARB   = 8'h02,
        S_START = 8'h04,
        S_WAIT  = 8'h08,
        S_DONE  = 8'h10,
        S_FAIL  = 8'h20
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);

    state_t      state_q;
    logic [3:0]  gnt_q;
    logic [3:0]  ack_q;
    logic        err_q;
    logic [11:0] data_len_q;
    logic [15:0] part_q;
    logic [13:0] seq_q;
    logic [1:0]  ptr_q;
    logic [1:0]  win_q;
    logic [15:0] cnt_q;

    logic        found_d;
    logic [1:0]  win_d;
    logic [11:0] len_d;

    // Search starts at ptr and wraps; 2-bit index arithmetic does the wrap.
    always_comb begin
        found_d = 1'b0;
        win_d   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!found_d && bus.req[ptr_q + 2'(k)]) begin
                found_d = 1'b1;
                win_d   = ptr_q + 2'(k);
            end
        end
        len_d = bus.len_bus[32'(win_d) * 12 +: 12];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            data_len_q <= '0;
            part_q     <= '0;
            seq_q      <= '0;
            ptr_q      <= '0;
            win_q      <= '0;
            cnt_q      <= '0;
        end else begin
            ack_q <= '0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    gnt_q <= '0;
                    if (|bus.req) state_q <= S_ARB;
                end
                S_ARB: begin
                    if (found_d) begin
                        gnt_q      <= 4'b0001 << win_d;
                        win_q      <= win_d;
                        data_len_q <= len_d;
                        part_q     <= {win_d, seq_q};
                        // Zero-length grants complete at once and consume no sequence number.
                        if (len_d == 12'd0) begin
                            state_q <= S_DONE;
                            ack_q   <= 4'b0001 << win_d;
                            ptr_q   <= win_d + 2'd1;
                        end else begin
                            state_q <= S_START;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (bus.fd) begin
                        state_q <= S_DONE;
                        ack_q   <= 4'b0001 << win_q;
                        ptr_q   <= win_q + 2'd1;
                        seq_q   <= seq_q + 14'd1;
                    end else if (cnt_q == TO_LAST) begin
                        state_q <= S_FAIL;
                        err_q   <= 1'b1;
                        ptr_q   <= win_q + 2'd1;
                    end
                end
                S_DONE, S_FAIL: begin
                    // Linger until the writer has seen fs drop and released fd.
                    if (!bus.fd) begin
                        gnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fs       = (state_q == S_START) || (state_q == S_WAIT);
    assign bus.so       = state_q;
    assign bus.gnt      = gnt_q;
    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.data_len = data_len_q;
    assign bus.part     = part_q;
endmodule

// File: tb/tb_fifo_write_sched.sv
// Bench for fifo_write_sched: directed scenarios plus random traffic, checked
// against a packet-level model of round-robin order, headers and outcomes.
module tb_fifo_write_sched;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifo_write_sched_if bus();

    fifo_write_sched #(.TO_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Sources and writer stimulus state
    logic [3:0]  pending = '0;
    logic [3:0]  rf      = '0;
    logic [11:0] src_len [4];
    bit          auto_src = 1'b0;
    bit          refill   = 1'b0;
    int          force_d  = 0;
    logic        fd_drv   = 1'b0;
    int          hold_left = 0;
    int          wr_k = 0;
    int          d_cur = 0;
    int          h_cur = 0;

    // Reference model and scoreboard
    logic [1:0]  ptr_m = '0;
    logic [13:0] seq_m = '0;
    logic [7:0]  exp_q [$];
    logic [1:0]  cur_win = '0;
    logic [11:0] cur_len = '0;
    bit          in_pkt = 1'b0;
    int          exp_fs = 0;
    int          exp_hold = 0;
    int          fs_cnt = 0;
    int          fs_rise_cyc = 0;
    int          done_cyc = 0;
    int          cyc = 0;
    int          err_cnt = 0;
    int          ack_cnt = 0;
    logic [3:0]  gnt_prev = '0;
    logic [3:0]  ack_prev = '0;
    logic        err_prev = 1'b0;
    logic [3:0]  log_gnt [$];
    logic [15:0] log_part [$];
    logic [11:0] log_len [$];
    int          log_fs [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        for (int k = 0; k < 4; k++) begin
            if (r[(int'(p) + k) % 4]) return 2'((int'(p) + k) % 4);
        end
        return p;
    endfunction

    task automatic apply();
        bus.req = pending;
        for (int i = 0; i < 4; i++) bus.len_bus[12*i +: 12] = src_len[i];
        bus.fd = fd_drv;
    endtask

    task automatic model_reset();
        ptr_m = '0;
        seq_m = '0;
        exp_q.delete();
        in_pkt = 1'b0;
        fd_drv = 1'b0;
        hold_left = 0;
        wr_k = 0;
        gnt_prev = '0;
        ack_prev = '0;
        err_prev = 1'b0;
        pending = '0;
        rf = '0;
        apply();
    endtask

    task automatic raise_req(input int src, input logic [11:0] len);
        src_len[src] = len;
        pending[src] = 1'b1;
        apply();
    endtask

    task automatic monitor();
        logic [1:0] w;
        logic [7:0] obs;
        logic [7:0] e;
        if (gnt_prev == 4'b0 && bus.gnt != 4'b0) begin
            w = rr_pick(bus.req, ptr_m);
            check("gnt", bus.gnt, 4'b0001 << w);
            check("data_len", bus.data_len, src_len[w]);
            check("part", bus.part, {w, seq_m});
            log_gnt.push_back(bus.gnt);
            log_part.push_back(bus.part);
            log_len.push_back(bus.data_len);
            cur_win = w;
            cur_len = src_len[w];
            wr_k = 0;
            fs_cnt = 0;
            in_pkt = 1'b1;
            if (cur_len == 12'd0) begin
                d_cur = 0;
                h_cur = 0;
                exp_fs = 0;
                exp_hold = 0;
                e = {2'b01, 2'b00, 4'b0001 << w};
            end else begin
                d_cur = (force_d != 0) ? force_d : int'($urandom_range(2, TO + 3));
                h_cur = int'($urandom_range(0, 2));
                // fd arriving by the last watchdog cycle wins; later means abort.
                if (d_cur <= TO + 1) begin
                    exp_fs = d_cur;
                    exp_hold = h_cur;
                    e = {2'b01, 2'b00, 4'b0001 << w};
                end else begin
                    exp_fs = TO + 1;
                    exp_hold = 0;
                    e = {2'b10, 2'b00, 4'b0001 << w};
                end
            end
            exp_q.push_back(e);
        end
        if (bus.ack != 4'b0 || bus.err) begin
            obs = {bus.err, |bus.ack, 2'b00, bus.err ? bus.gnt : bus.ack};
            if (bus.err) err_cnt++;
            if (bus.ack != 4'b0) ack_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_end", obs, 8'h00);
            end else begin
                e = exp_q.pop_front();
                check("end", obs, e);
                ptr_m = cur_win + 2'd1;
                if (e[6] && cur_len != 12'd0) seq_m = seq_m + 14'd1;
            end
            done_cyc = cyc;
        end
        if (ack_prev != 4'b0) check("ack_pulse", bus.ack, 4'b0);
        if (err_prev) check("err_pulse", bus.err, 1'b0);
        if (!in_pkt) check("fs_idle", bus.fs, 1'b0);
        if (in_pkt && bus.fs) begin
            fs_cnt++;
            if (fs_cnt == 1) fs_rise_cyc = cyc;
        end
        if (gnt_prev != 4'b0 && bus.gnt == 4'b0) begin
            check("fs_cycles", fs_cnt, exp_fs);
            check("dwell", cyc - done_cyc, 1 + exp_hold);
            log_fs.push_back(fs_cnt);
            in_pkt = 1'b0;
        end
        gnt_prev = bus.gnt;
        ack_prev = bus.ack;
        err_prev = bus.err;
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (rf[i]) begin
                pending[i] = 1'b1;
                rf[i] = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.ack[i]) begin
                pending[i] = 1'b0;
                if (refill) rf[i] = 1'b1;
            end
        end
        if (auto_src) begin
            for (int i = 0; i < 4; i++) begin
                if (!pending[i] && !bus.ack[i] && $urandom_range(0, 3) == 0) begin
                    src_len[i] = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
                    pending[i] = 1'b1;
                end
            end
        end
        if (in_pkt && bus.fs) begin
            wr_k++;
            if (wr_k == d_cur) begin
                fd_drv = 1'b1;
                hold_left = h_cur;
            end
        end else if (fd_drv && !bus.fs) begin
            if (hold_left > 0) hold_left--;
            else fd_drv = 1'b0;
        end
        apply();
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
        drive();
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n = 0;
        while (!(pending == 4'b0 && rf == 4'b0 && !in_pkt && bus.gnt == 4'b0 && !fd_drv)
               && n < max_cyc) begin
            cycle();
            n++;
        end
        check("idle_reached", n < max_cyc, 1'b1);
        cycle();
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        pending = '0;
        fd_drv = 1'b0;
        apply();
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b1;
        model_reset();
    endtask

    logic [15:0] fair_part [5];
    logic [3:0]  fair_gnt [5];

    initial begin
        int b;
        int rc;
        int n;
        int e0;
        int a0;
        fair_part = '{16'h0000, 16'h4001, 16'h8002, 16'hC003, 16'h0004};
        fair_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 4; i++) src_len[i] = '0;
        apply();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_so", bus.so, 8'h01);
        check("rst_gnt", bus.gnt, 4'b0);
        check("rst_ack", bus.ack, 4'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_fs", bus.fs, 1'b0);
        check("rst_len", bus.data_len, 12'd0);
        check("rst_part", bus.part, 16'h0000);
        rst = 1'b1;
        model_reset();

        // Single request, then a second packet from the same source
        b = log_part.size();
        force_d = 12;
        raise_req(0, 12'd10);
        rc = cyc;
        run_until_idle(100);
        check("fs_latency", fs_rise_cyc - rc, 2);
        check("single_len", log_len[b], 12'd10);
        check("single_part", log_part[b], 16'h0000);
        raise_req(0, 12'd5);
        run_until_idle(100);
        check("second_part", log_part[b+1], 16'h0001);

        // Fairness with every source re-requesting after its ack
        pulse_reset();
        b = log_part.size();
        force_d = 3;
        refill = 1'b1;
        for (int i = 0; i < 4; i++) raise_req(i, 12'(20 + i));
        n = 0;
        while (log_part.size() < b + 5 && n < 300) begin
            cycle();
            n++;
        end
        refill = 1'b0;
        run_until_idle(300);
        for (int i = 0; i < 5; i++) begin
            check("fair_gnt", log_gnt[b+i], fair_gnt[i]);
            check("fair_part", log_part[b+i], fair_part[i]);
        end

        // Zero-length grant: ack the cycle after ARB, no writer start
        raise_req(2, 12'd0);
        rc = cyc;
        a0 = ack_cnt;
        n = 0;
        while (ack_cnt == a0 && n < 20) begin
            cycle();
            n++;
        end
        check("zero_ack_lat", cyc - rc, 2);
        run_until_idle(50);

        // Watchdog abort, then the pointer must have moved past source 1
        b = log_gnt.size();
        e0 = err_cnt;
        force_d = 1000;
        raise_req(1, 12'd7);
        n = 0;
        while (err_cnt == e0 && n < 100) begin
            cycle();
            n++;
        end
        check("err_seen", err_cnt - e0, 1);
        force_d = 4;
        raise_req(0, 12'd9);
        run_until_idle(200);
        check("to_fs", log_fs[b], TO + 1);
        check("to_next_gnt", log_gnt[b+1], 4'b0001);
        check("err_once", err_cnt - e0, 1);

        // fd on the same cycle the watchdog expires
        e0 = err_cnt;
        a0 = ack_cnt;
        b = log_fs.size();
        force_d = TO + 1;
        raise_req(3, 12'd50);
        run_until_idle(100);
        check("tie_err", err_cnt - e0, 0);
        check("tie_ack", ack_cnt - a0, 1);
        check("tie_fs", log_fs[b], TO + 1);

        // Random traffic
        force_d = 0;
        auto_src = 1'b1;
        repeat (3000) cycle();
        auto_src = 1'b0;
        force_d = 5;
        run_until_idle(3000);

        // Reset while waiting on the writer
        force_d = 1000;
        raise_req(1, 12'd100);
        n = 0;
        while (!(in_pkt && wr_k == 5) && n < 50) begin
            cycle();
            n++;
        end
        check("reach_wait", n < 50, 1'b1);
        rst = 1'b0;
        pending = '0;
        fd_drv = 1'b0;
        apply();
        @(posedge clk);
        #1;
        cyc++;
        check("midrst_fs", bus.fs, 1'b0);
        check("midrst_gnt", bus.gnt, 4'b0);
        check("midrst_so", bus.so, 8'h01);
        rst = 1'b1;
        model_reset();
        force_d = 3;
        b = log_part.size();
        raise_req(3, 12'd20);
        run_until_idle(100);
        check("part_after_rst", log_part[b], 16'hC000);

        check("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
